sim_run_ctrl: RTL
=================

Name: sim_run_ctrl

Overview:
Parametrised run controller for simulation and FPGA bring-up of the RISC-V top.
- Holds the core in reset for a programmable number of cycles after release.
- Counts run cycles and ends the run on a halt write to a magic MMIO address, on a cycle-budget timeout, or on an external restart.
- Latches the exit code, cycle count and termination reason for the bench or LED/UART reporting.

Parameters:
RST_CYCLES, 25, clock edges core_rst stays high after rst deasserts; legal range >= 1
MAX_CYCLES, 500000, run-cycle budget; 0 = unlimited (counter saturates)
CNT_W, 32, width of cycle counter
ADDR_W, 32, width of monitored memory address
HALT_ADDR, 32'h00030004, address whose write ends the run

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
restart  input  1  synchronous pulse; re-enters reset sequence
mem_wr  input  1  core memory write strobe, valid per cycle
mem_a  input  ADDR_W  core memory address
mem_dout  input  8  core write data byte
core_rst  output  1  reset to core, active-high
done  output  1  run finished, level, held until restart/rst
done_reason  output  2  0 none, 1 halt, 2 timeout, 3 abort
exit_code  output  8  byte written at HALT_ADDR; valid when done and reason is halt
cycle_cnt  output  CNT_W  run cycles elapsed

Behaviour:
- All outputs are registered.
- Reset values while rst=1: state=HOLD, core_rst=1, done=0, done_reason=0, exit_code=0, cycle_cnt=0, hold counter=0.
- HOLD state:
  - Hold counter increments each edge.
  - At the edge where it equals RST_CYCLES-1: go to RUN, core_rst<=0.
  - Result: core_rst is high for exactly RST_CYCLES edges after rst falls.
  - mem_wr is ignored in HOLD.
- RUN state, each edge:
  - cycle_cnt<=cycle_cnt+1; saturates at all-ones when MAX_CYCLES=0.
  - Halt: mem_wr=1 && mem_a==HALT_ADDR -> DONE, done<=1, done_reason<=1, exit_code<=mem_dout, core_rst<=1. The halt cycle is counted in cycle_cnt.
  - Timeout: MAX_CYCLES!=0 && cycle_cnt==MAX_CYCLES-1 -> DONE, reason 2, core_rst<=1, cycle_cnt becomes MAX_CYCLES.
  - Halt and timeout on the same edge: halt wins (reason 1, exit code latched).
- DONE state:
  - cycle_cnt, exit_code and done_reason are frozen.
  - core_rst=1; further mem_wr is ignored.
- Restart:
  - restart=1 in any state -> HOLD, hold counter<=0, cycle_cnt<=0, core_rst<=1, done<=0, exit_code<=0.
  - In RUN, restart takes priority over halt and timeout. done_reason<=3 (abort) and stays 3 through the next HOLD, for bench visibility; it is overwritten at the next DONE.
  - In HOLD or DONE, restart clears done_reason to 0.
  - restart held high keeps the block in HOLD with the counter at 0.
- Asynchronous rst mid-run: immediately returns all state to reset values regardless of phase.
- Address compare is full-width equality; no byte-lane masking.
- Legality: RST_CYCLES=0 is illegal; guard with an elaboration-time check.
- Legality: MAX_CYCLES must fit in CNT_W.

Decomposition:
- Shared package sim_pkg:
  - state enum {HOLD, RUN, DONE}
  - reason constants REASON_NONE/HALT/TIMEOUT/ABORT
  - default HALT_ADDR constant
- One natural sub-module: sat_counter (parametrised width, enable, clear, saturate). Instantiated twice: hold counter and cycle counter.
- Top-level testbench instantiates sim_run_ctrl beside riscv_top. The bench calls $finish on done instead of a fixed repeat count.

Test Plan:
1. Reset timing: RST_CYCLES=4, rst high then low. core_rst is high for exactly 4 edges after rst falls, then 0; cycle_cnt starts at 1 on the first RUN edge.
2. Halt: MAX_CYCLES=0; drive mem_wr=1, mem_a=0x30004, mem_dout=0x5A on run cycle 100. Next edge: done=1, done_reason=1, exit_code=0x5A, cycle_cnt=100, core_rst=1. Values stay frozen 20 cycles later.
3. Timeout and tie: MAX_CYCLES=50, no halt. done=1, reason=2, cycle_cnt=50. Repeat with the halt write on cycle 50: reason=1.
4. Non-matching write and saturation: mem_wr at 0x30000 and 0x30005 never trigger. With CNT_W=4 and MAX_CYCLES=0, cycle_cnt saturates at 15.
5. Abort/restart: restart pulse on run cycle 30 -> reason=3, core_rst=1 for RST_CYCLES edges, cycle_cnt=0. Then a halt run completes normally. A restart in DONE clears done and reason.
6. Async reset mid-run: assert rst between clock edges during RUN. Outputs go to reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/sim_pkg.sv
// Shared types and constants for the simulation run controller.
// Run phases, termination reason codes and the default halt address.
package sim_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] REASON_NONE    = 2'd0;
  localparam logic [1:0] REASON_HALT    = 2'd1;
  localparam logic [1:0] REASON_TIMEOUT = 2'd2;
  localparam logic [1:0] REASON_ABORT   = 2'd3;

  localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h00030004;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
// Clear has priority so a held clear keeps the count at zero.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: holds the core in reset, counts run cycles and ends the run
// on a halt write, a cycle-budget timeout or an external restart.
module sim_run_ctrl
  import sim_pkg::*;
#(
  parameter int unsigned       RST_CYCLES = 25,
  parameter int unsigned       MAX_CYCLES = 500000,
  parameter int                CNT_W      = 32,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(HALT_ADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_a,
  input  logic [7:0]        mem_dout,
  output logic              core_rst,
  output logic              done,
  output logic [1:0]        done_reason,
  output logic [7:0]        exit_code,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam logic [1:0] ST_HOLD = HOLD;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  // Wide enough to hold RST_CYCLES, the value reached on the exit edge.
  localparam int HOLD_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam bit                HAS_TMO   = (MAX_CYCLES != 0);

  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("sim_run_ctrl: RST_CYCLES must be at least 1");
  end

  if (CNT_W < 32) begin : g_narrow_cnt
    if ((MAX_CYCLES >> CNT_W) != 0) begin : g_bad_max_cycles
      $error("sim_run_ctrl: MAX_CYCLES does not fit in CNT_W bits");
    end
  end

  logic [1:0]        state_reg;
  logic              core_rst_reg;
  logic              done_reg;
  logic [1:0]        reason_reg;
  logic [7:0]        exit_reg;
  logic [HOLD_W-1:0] hold_cnt;

  logic in_hold;
  logic in_run;
  logic hold_last;
  logic halt_hit;
  logic tmo_hit;

  assign in_hold   = (state_reg == ST_HOLD);
  assign in_run    = (state_reg == ST_RUN);
  assign hold_last = in_hold && (hold_cnt == HOLD_LAST);
  assign halt_hit  = in_run && mem_wr && (mem_a == HALT_ADDR);
  assign tmo_hit   = in_run && HAS_TMO && (cycle_cnt == TMO_LAST);

  sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .en  (in_hold),
    .clr (restart),
    .q   (hold_cnt)
  );

  // The edge that ends a run still counts, so the budget lands on MAX_CYCLES.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .en  (in_run),
    .clr (restart),
    .q   (cycle_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_HOLD;
      core_rst_reg <= 1'b1;
      done_reg     <= 1'b0;
      reason_reg   <= REASON_NONE;
      exit_reg     <= 8'h00;
    end else if (restart) begin
      // Abort stays visible through the following hold phase.
      state_reg    <= ST_HOLD;
      core_rst_reg <= 1'b1;
      done_reg     <= 1'b0;
      reason_reg   <= in_run ? REASON_ABORT : REASON_NONE;
      exit_reg     <= 8'h00;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (hold_last) begin
            state_reg    <= ST_RUN;
            core_rst_reg <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt_hit) begin
            state_reg    <= ST_DONE;
            core_rst_reg <= 1'b1;
            done_reg     <= 1'b1;
            reason_reg   <= REASON_HALT;
            exit_reg     <= mem_dout;
          end else if (tmo_hit) begin
            state_reg    <= ST_DONE;
            core_rst_reg <= 1'b1;
            done_reg     <= 1'b1;
            reason_reg   <= REASON_TIMEOUT;
          end
        end
        ST_DONE: begin
          core_rst_reg <= 1'b1;
        end
        default: begin
          state_reg    <= ST_HOLD;
          core_rst_reg <= 1'b1;
        end
      endcase
    end
  end

  assign core_rst    = core_rst_reg;
  assign done        = done_reg;
  assign done_reason = reason_reg;
  assign exit_code   = exit_reg;

endmodule
